// File: rtl/rv32_data_mem_responder_if.sv
// Request/response signals of the CPU data-side memory port (the shared data bus stays a plain inout).
// The CPU side is the master and the memory responder is the slave.
interface rv32_data_mem_responder_if;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  addMemControl;
    logic        memUnsigned;
    logic        memReady;
    logic        memErr;

    modport master (
        output MemAddr, MemRead, MemWrite, addMemControl, memUnsigned,
        input  memReady, memErr
    );

    modport slave (
        input  MemAddr, MemRead, MemWrite, addMemControl, memUnsigned,
        output memReady, memErr
    );
endinterface

// File: rtl/rv32_data_mem_responder.sv
// Data-memory responder: word RAM with byte/half/word lane steering, load extension and a wait-state handshake.
// Optional macro DMEM_MISALIGN_ERR_EN rejects misaligned and size-11 accesses instead of aligning them down.
module rv32_data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    rv32_data_mem_responder_if.slave  bus,
    inout  wire  [31:0]               data
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [3:0]      wait_cnt;

    logic [AW-1:0]   cap_idx;
    logic [1:0]      cap_lane, cap_size;
    logic            cap_uns, cap_rd, cap_wr;
    logic [31:0]     cap_wdata;

    logic [AW-1:0]   src_idx;
    logic [1:0]      src_lane, src_size;
    logic            src_uns, src_rd, src_wr;
    logic [31:0]     src_wdata;

    logic [1:0]      eff_lane, eff_size;
    logic            src_err, commit, wr_en, req;
    logic [3:0]      byte_en;
    logic [31:0]     wr_word, rd_word, ld_val, load_q;
    logic [15:0]     sel_half;
    logic [7:0]      sel_byte;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            unused_addr_bits;
    assign unused_addr_bits = ^bus.MemAddr[31:AW+2];

    assign req = bus.MemRead | bus.MemWrite;

    // In IDLE the live request drives the datapath so a zero-wait access can commit on its capture edge.
    always_comb begin
        if (state == IDLE) begin
            src_idx   = bus.MemAddr[AW+1:2];
            src_lane  = bus.MemAddr[1:0];
            src_size  = bus.addMemControl;
            src_uns   = bus.memUnsigned;
            src_rd    = bus.MemRead;
            src_wr    = bus.MemWrite;
            src_wdata = data;
        end else begin
            src_idx   = cap_idx;
            src_lane  = cap_lane;
            src_size  = cap_size;
            src_uns   = cap_uns;
            src_rd    = cap_rd;
            src_wr    = cap_wr;
            src_wdata = cap_wdata;
        end
    end

    always_comb begin
        eff_size = (src_size == 2'b11) ? 2'b10 : src_size;
        case (eff_size)
            2'b00:   eff_lane = src_lane;
            2'b01:   eff_lane = {src_lane[1], 1'b0};
            default: eff_lane = 2'b00;
        endcase
`ifdef DMEM_MISALIGN_ERR_EN
        src_err = (src_rd & src_wr)
                | (src_size == 2'b11)
                | ((src_size == 2'b01) & src_lane[0])
                | ((src_size == 2'b10) & (src_lane != 2'b00));
`else
        src_err = src_rd & src_wr;
`endif
    end

    always_comb begin
        case (eff_size)
            2'b00: begin
                wr_word = {4{src_wdata[7:0]}};
                byte_en = 4'b0001 << eff_lane;
            end
            2'b01: begin
                wr_word = {2{src_wdata[15:0]}};
                byte_en = eff_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_word = src_wdata;
                byte_en = 4'b1111;
            end
        endcase
    end

    always_comb begin
        rd_word  = mem[src_idx];
        sel_half = eff_lane[1] ? rd_word[31:16] : rd_word[15:0];
        sel_byte = rd_word[{eff_lane, 3'b000} +: 8];
        case (eff_size)
            2'b00:   ld_val = src_uns ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            2'b01:   ld_val = src_uns ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: ld_val = rd_word;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign commit = (state != RESP) && (state_nx == RESP);
    assign wr_en  = commit & src_wr & ~src_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_idx   <= '0;
            cap_lane  <= '0;
            cap_size  <= '0;
            cap_uns   <= 1'b0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
            cap_wdata <= '0;
            load_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                cap_idx   <= src_idx;
                cap_lane  <= src_lane;
                cap_size  <= src_size;
                cap_uns   <= src_uns;
                cap_rd    <= src_rd;
                cap_wr    <= src_wr;
                cap_wdata <= src_wdata;
                wait_cnt  <= WAIT_INIT;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) load_q <= src_err ? '0 : ld_val;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[src_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    assign bus.memReady = (state == RESP);
    assign bus.memErr   = (state == RESP) & src_err;
    assign data         = (state == RESP && src_rd && !src_wr) ? load_q : 'z;
endmodule
